aes_inv_cipher_iter: RTL and testbench

//  AES-128 decryption core, iterative: one inverse round per clock. It is the

---
 rtl/aes_inv_cipher_iter_pkg.sv | 146 ++++++++++++++
 rtl/aes_inv_round.sv | 17 +
 rtl/aes_inv_cipher_iter.sv | 110 +++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES-128 types and GF(2^8) helpers.
// Both S-boxes come from the field inverse plus the affine map.
package aes_inv_cipher_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } state_t;

    localparam logic [3:0] NR = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x,
                                         input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3)
                 ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] v;
        v = rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05;
        return ginv(v);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k,
                                                input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                   input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_sub_bytes128(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    // Inverse ShiftRows: row r rotates right by r columns
    function automatic logic [127:0] right_shift128(input logic [127:0] s);
        logic [127:0] r;
        int src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                src = 4 * ((c + 4 - w) % 4) + w;
                r[127-8*(4*c+w) -: 8] = s[127-8*src -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_col128(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                             ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                             ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                             ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                             ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// The last round skips InvMixColumns.
module aes_inv_round
    import aes_inv_cipher_iter_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] kprev,
    input  logic         last,
    output logic [127:0] state_next
);

    logic [127:0] t;

    assign t = add_round_key(inv_sub_bytes128(right_shift128(state)), kprev);
    assign state_next = last ? t : inv_mix_col128(t);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: ten forward key-schedule steps,
// then ten inverse rounds walking the schedule backwards.
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] cipher,
    output logic         busy,
    output logic         valid,
    output logic [127:0] plain
);

    state_t       state, state_n;
    logic [127:0] kreg, kreg_n;
    logic [127:0] creg, creg_n;
    logic [127:0] sreg, sreg_n;
    logic [3:0]   cnt, cnt_n;
    logic         busy_n, valid_n;
    logic [127:0] plain_n;

    logic [127:0] kexp, kprev, rnd;
    logic [31:0]  p0, p1, p2, p3;
    logic [7:0]   rc;

    assign rc   = rcon(cnt);
    assign kexp = expand_key(kreg, rc);

    // Undo one key-expansion step: k(cnt) -> k(cnt-1)
    assign p3    = kreg[31:0] ^ kreg[63:32];
    assign p2    = kreg[63:32] ^ kreg[95:64];
    assign p1    = kreg[95:64] ^ kreg[127:96];
    assign p0    = kreg[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h0};
    assign kprev = {p0, p1, p2, p3};

    aes_inv_round u_round (
        .state      (sreg),
        .kprev      (kprev),
        .last       (cnt == 4'd1),
        .state_next (rnd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            kreg  <= '0;
            creg  <= '0;
            sreg  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            plain <= '0;
        end else begin
            state <= state_n;
            kreg  <= kreg_n;
            creg  <= creg_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            valid <= valid_n;
            plain <= plain_n;
        end
    end

    always_comb begin
        state_n = state;
        kreg_n  = kreg;
        creg_n  = creg;
        sreg_n  = sreg;
        cnt_n   = cnt;
        busy_n  = busy;
        valid_n = 1'b0;
        plain_n = plain;
        unique case (state)
            IDLE: begin
                if (start) begin
                    kreg_n  = key;
                    creg_n  = cipher;
                    cnt_n   = 4'd1;
                    busy_n  = 1'b1;
                    state_n = KEXP;
                end
            end
            KEXP: begin
                kreg_n = kexp;
                cnt_n  = cnt + 4'd1;
                if (cnt == NR) begin
                    sreg_n  = add_round_key(creg, kexp);
                    cnt_n   = NR;
                    state_n = DEC;
                end
            end
            DEC: begin
                kreg_n = kprev;
                sreg_n = rnd;
                cnt_n  = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    plain_n = rnd;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known vectors, timing corners,
// and a random round-trip against an independent encryption model.
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] cipher = '0;
    logic         busy;
    logic         valid;
    logic [127:0] plain;

    always #5 clk = ~clk;

    aes_inv_cipher_iter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .key    (key),
        .cipher (cipher),
        .busy   (busy),
        .valid  (valid),
        .plain  (plain)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] cipher;
        logic [127:0] plain;
    } vec_t;

    vec_t         tbl[2];
    logic [127:0] exp_q[$];
    logic [7:0]   sb[256];
    logic [127:0] prev_plain = '0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int busy_cnt = 0;
    int last_vcyc = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, req);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (rst_n && valid) begin
            vcnt++;
            last_vcyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got=%h want=none", plain);
            end else begin
                chk("plain", plain, exp_q.pop_front());
            end
        end
        if (rst_n && !valid) chk("plain_hold", plain, prev_plain);
        prev_plain = plain;
    end

    // ---------------- reference encryption model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sb[x] = b;
        end
    endtask

    function automatic logic [127:0] m_kexp(input logic [127:0] k,
                                            input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ {sb[k[23:16]] ^ rc, sb[k[15:8]],
                          sb[k[7:0]], sb[k[31:24]]};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] s,
                                             input logic mix);
        logic [7:0] b[16];
        logic [7:0] t[16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[4*c+w] = b[4*((c+w)%4)+w];
        for (int c = 0; c < 4; c++) begin
            if (mix) begin
                b[4*c]   = gm(t[4*c],2)^gm(t[4*c+1],3)^t[4*c+2]^t[4*c+3];
                b[4*c+1] = t[4*c]^gm(t[4*c+1],2)^gm(t[4*c+2],3)^t[4*c+3];
                b[4*c+2] = t[4*c]^t[4*c+1]^gm(t[4*c+2],2)^gm(t[4*c+3],3);
                b[4*c+3] = gm(t[4*c],3)^t[4*c+1]^t[4*c+2]^gm(t[4*c+3],2);
            end else begin
                for (int w = 0; w < 4; w++) b[4*c+w] = t[4*c+w];
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic logic [127:0] m_enc(input logic [127:0] k,
                                           input logic [127:0] p);
        logic [127:0] s, rk;
        logic [7:0] rc;
        s = p ^ k;
        rk = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = m_kexp(rk, rc);
            rc = xt(rc);
            s = m_round(s, r != 10) ^ rk;
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Call just after a falling edge; the next rising edge is E0
    task automatic drive(input logic [127:0] k, input logic [127:0] c,
                         output int s);
        start = 1'b1;
        key = k;
        cipher = c;
        s = cyc;
        busy_cnt = 0;
        tick();
        start = 1'b0;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        cipher = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_valid(input int target, input string nm);
        int n;
        n = 0;
        while (vcnt < target && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (vcnt < target) begin
            errors++;
            $display("FAIL %s_timeout got=%0d want=%0d", nm, vcnt, target);
        end
    endtask

    initial begin
        int s, s2, v0, first, n;
        logic [127:0] k, p;

        build_sbox();
        tbl[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   128'h00112233445566778899aabbccddeeff};
        tbl[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3925841d02dc09fbdc118597196a0b32,
                   128'h3243f6a8885a308d313198a2e0370734};

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 128'(busy), 0);
        chk("rst_valid", 128'(valid), 0);
        chk("rst_plain", plain, 0);
        rst_n = 1'b1;
        tick();

        // Known vectors: latency and busy window
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(tbl[i].plain);
            v0 = vcnt;
            drive(tbl[i].key, tbl[i].cipher, s);
            wait_valid(v0 + 1, "vec");
            chk("latency", 128'(last_vcyc - s), 21);
            chk("busy_cycles", 128'(busy_cnt), 20);
        end
        repeat (3) tick();

        // Start while busy is ignored
        exp_q.push_back(tbl[0].plain);
        v0 = vcnt;
        drive(tbl[0].key, tbl[0].cipher, s);
        repeat (4) tick();
        start = 1'b1;
        key = tbl[1].key;
        cipher = tbl[1].cipher;
        tick();
        start = 1'b0;
        wait_valid(v0 + 1, "busy_start");
        chk("busy_start_lat", 128'(last_vcyc - s), 21);
        repeat (25) tick();
        chk("single_valid", 128'(vcnt), 128'(v0 + 1));

        // Back-to-back: new start accepted in the valid cycle
        exp_q.push_back(tbl[0].plain);
        v0 = vcnt;
        drive(tbl[0].key, tbl[0].cipher, s);
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_first", 128'(vcnt), 128'(v0 + 1));
        first = last_vcyc;
        exp_q.push_back(tbl[1].plain);
        drive(tbl[1].key, tbl[1].cipher, s2);
        wait_valid(v0 + 2, "b2b");
        chk("b2b_gap", 128'(last_vcyc - first), 21);
        repeat (3) tick();

        // Reset mid-operation aborts
        v0 = vcnt;
        drive(tbl[0].key, tbl[0].cipher, s);
        while (cyc < s + 12) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 128'(busy), 0);
        chk("abort_valid", 128'(valid), 0);
        chk("abort_plain", plain, 0);
        rst_n = 1'b1;
        repeat (30) tick();
        chk("abort_no_valid", 128'(vcnt), 128'(v0));
        exp_q.push_back(tbl[0].plain);
        drive(tbl[0].key, tbl[0].cipher, s);
        wait_valid(v0 + 1, "after_abort");
        chk("after_abort_lat", 128'(last_vcyc - s), 21);
        repeat (2) tick();

        // Reset and start together: reset wins
        rst_n = 1'b0;
        start = 1'b1;
        key = tbl[1].key;
        cipher = tbl[1].cipher;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        chk("rst_start_busy", 128'(busy), 0);
        tick();
        chk("rst_start_idle", 128'(busy), 0);

        // Random round trip
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_q.push_back(p);
            v0 = vcnt;
            drive(k, m_enc(k, p), s);
            wait_valid(v0 + 1, "rand");
        end
        repeat (3) tick();
        chk("queue_empty", 128'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
